// File: rtl/q4_pkg.sv
// Shared definitions for the three-input majority / odd-parity unit.
//   RES_W   : width of the result bus
//   MAJ_BIT : bit position of the majority result
//   ODD_BIT : bit position of the odd-parity result
//   result_t: packed result bus {maj, odd3}
//   OUT_RST : result bus value after reset
package q4_pkg;

  localparam int unsigned RES_W   = 2;
  localparam int unsigned MAJ_BIT = 1;
  localparam int unsigned ODD_BIT = 0;

  // Field order places maj at bit 1 and odd3 at bit 0.
  typedef struct packed {
    logic maj;
    logic odd3;
  } result_t;

  localparam result_t OUT_RST = RES_W'(2'b00);

endpackage

// File: rtl/maj_odd3_core.sv
// Combinational three-input vote core.
//   a, b, c : input votes
//   maj     : majority of a, b, c
//   odd3    : odd parity (XOR) of a, b, c
module maj_odd3_core (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic maj,
  output logic odd3
);

  assign maj  = (a & b) | (a & c) | (b & c);
  assign odd3 = a ^ b ^ c;

endmodule

// File: rtl/q4_maj_odd3.sv
// Registered three-input majority and odd-parity unit.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : qualifies a, b, c this cycle
//   a, b, c   : vote inputs
//   out       : registered result, out[1] = maj, out[0] = odd3
//   out_valid : high for the cycle after an accepted sample
module q4_maj_odd3
  import q4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic [RES_W-1:0] out,
  output logic             out_valid
);

  logic    maj_c;
  logic    odd3_c;
  result_t res_q;
  logic    vld_q;

  // Vote core.
  maj_odd3_core u_core (
    .a    (a),
    .b    (b),
    .c    (c),
    .maj  (maj_c),
    .odd3 (odd3_c)
  );

  // Result register; only loads on accepted samples so X on idle inputs never enters.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= OUT_RST;
      vld_q <= 1'b0;
    end else begin
      if (in_valid) begin
        res_q.maj  <= maj_c;
        res_q.odd3 <= odd3_c;
      end
      vld_q <= in_valid;
    end
  end

  assign out[MAJ_BIT] = res_q.maj;
  assign out[ODD_BIT] = res_q.odd3;
  assign out_valid    = vld_q;

endmodule

// File: tb/tb_q4_maj_odd3.sv
// Self-checking bench for q4_maj_odd3: directed cases plus randomized traffic
// checked against a ones-count reference model.
module tb_q4_maj_odd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       a, b, c;
  logic [1:0] out;
  logic       out_valid;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference state.
  logic [1:0] exp_out;
  logic       exp_vld;

  q4_maj_odd3 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: majority is two-or-more ones, parity is the low bit of the count.
  function automatic logic [1:0] ref_result(input logic [2:0] v);
    int n;
    n = int'(v[0]) + int'(v[1]) + int'(v[2]);
    return {(n >= 2) ? 1'b1 : 1'b0, (n % 2 == 1) ? 1'b1 : 1'b0};
  endfunction

  // Apply one cycle of stimulus, advance the model, check after the edge.
  task automatic step(input string tag, input logic r, input logic v, input logic [2:0] abc);
    rst = r; in_valid = v; {a, b, c} = abc;
    @(posedge clk);
    if (r) begin
      exp_out = 2'b00; exp_vld = 1'b0;
    end else if (v) begin
      exp_out = ref_result(abc); exp_vld = 1'b1;
    end else begin
      exp_vld = 1'b0;
    end
    #1;
    check({tag, ".out"}, out, exp_out);
    check({tag, ".vld"}, {1'b0, out_valid}, {1'b0, exp_vld});
  endtask

  initial begin
    logic [2:0] directed [5];
    logic [1:0] expected [5];
    directed = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b010};
    expected = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
    exp_out = 2'b00; exp_vld = 1'b0;

    // Reset dominates a valid 111 sample.
    step("rst0", 1'b1, 1'b1, 3'b111);
    step("rst1", 1'b1, 1'b1, 3'b111);
    check("rst_const", out, 2'b00);
    step("post_rst", 1'b0, 1'b1, 3'b110);
    check("post_rst_const", out, 2'b10);

    // Directed sequence against hand-derived constants.
    for (int i = 0; i < 5; i++) begin
      step("dir", 1'b0, 1'b1, directed[i]);
      check("dir_const", out, expected[i]);
      check("dir_vld", {1'b0, out_valid}, 2'b01);
    end

    // Exhaustive back-to-back sweep.
    for (int i = 0; i < 8; i++) step("sweep", 1'b0, 1'b1, 3'(i));

    // Hold with in_valid low.
    step("hold_load", 1'b0, 1'b1, 3'b111);
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b0, 1'b0, 3'b000);
      check("hold_const", out, 2'b11);
    end

    // Reset mid-stream discards the pending sample.
    step("mid_pre", 1'b0, 1'b1, 3'b001);
    step("mid_rst", 1'b1, 1'b1, 3'b011);
    step("mid_after", 1'b0, 1'b0, 3'b011);
    check("mid_const", out, 2'b00);

    // X isolation while idle.
    step("x_load", 1'b0, 1'b1, 3'b101);
    for (int i = 0; i < 4; i++) begin
      step("xiso", 1'b0, 1'b0, 3'bxxx);
      check("xiso_known", {1'b0, ^{out, out_valid} === 1'bx}, 2'b00);
    end

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
